// File: rtl/tdm_demux4_if.sv
// Bundle of the TDM receive-side stream and the demultiplexed channel outputs.
// The transmit/stimulus side uses the master modport and tdm_demux4 uses the slave modport.
interface tdm_demux4_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] din;
    logic             valid;
    logic             sof;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       sel;
    logic             frame_valid;
    logic             sync_err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output din, valid, sof,
        input  a, b, c, d, sel, frame_valid, sync_err, frame_cnt
    );

    modport slave (
        input  din, valid, sof,
        output a, b, c, d, sel, frame_valid, sync_err, frame_cnt
    );
endinterface

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: collects slots 0..2 into shadow registers and
// publishes all four channels together on the edge that samples slot 3.
// An early start-of-frame drops the partial frame and restarts at slot 0.
module tdm_demux4 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    tdm_demux4_if.slave   bus
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t           state_q;
    logic [1:0]       sel_q;
    logic [WIDTH-1:0] sh0_q;
    logic [WIDTH-1:0] sh1_q;
    logic [WIDTH-1:0] sh2_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;
    logic             fv_q;
    logic             se_q;
    logic [CNT_W-1:0] cnt_q;

    // Slot sequencing, shadow capture, and frame publish/resync with registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            fv_q <= 1'b0;
            se_q <= 1'b0;
            if (bus.valid) begin
                if (bus.sof) begin
                    // sof takes priority over completion, so slot-3 sof is a resync
                    se_q    <= (state_q == COLLECT);
                    sh0_q   <= bus.din;
                    sel_q   <= 2'd1;
                    state_q <= COLLECT;
                end else if (state_q == COLLECT) begin
                    if (sel_q == 2'd3) begin
                        a_q     <= sh0_q;
                        b_q     <= sh1_q;
                        c_q     <= sh2_q;
                        d_q     <= bus.din;
                        fv_q    <= 1'b1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        sel_q   <= 2'd0;
                        state_q <= IDLE;
                    end else begin
                        // In COLLECT, sel is only ever 1, 2 or 3
                        if (sel_q == 2'd1) begin
                            sh1_q <= bus.din;
                        end else begin
                            sh2_q <= bus.din;
                        end
                        sel_q <= sel_q + 2'd1;
                    end
                end
            end
        end
    end

    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.c           = c_q;
    assign bus.d           = d_q;
    assign bus.sel         = sel_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.frame_cnt   = cnt_q;

endmodule
